heichips25_result_uart_tx: RTL and testbench
============================================

# heichips25_result_uart_tx

Downstream serializer for a HeiChips25 user project's 8-bit result bus (e.g. the `uo_out` sum). It accepts one byte per valid/ready handshake and transmits it as an asynchronous UART frame on one pin: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits. A single output pin then carries results off-chip instead of eight.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit. Legal range is 2 to 65535; other values are a design error.
- `PARITY`, default 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, default 1: legal values are 1 or 2.

Ports:
- `clk`  in  1  — single clock; all logic on the rising edge.
- `rst`  in  1  — synchronous reset, active-high; overrides every other input.
- `data_in`  in  8  — byte to transmit, typically the user project's `uo_out`.
- `valid_in`  in  1  — `data_in` holds a byte offered for transmission.
- `ready_out`  out  1  — registered; high only in IDLE.
- `tx`  out  1  — registered serial line; idle-high.
- `busy`  out  1  — registered; high from the cycle after acceptance until the frame ends.

## Operation

- Frame length `N = 1 + 8 + (PARITY != 0) + STOP_BITS` bits. With defaults (8N1), `N = 10` and the frame is 160 cycles.
- Handshake: a byte is accepted on a rising edge where `valid_in && ready_out && !rst`.
  - On acceptance, `data_in` is latched into the shift register. Later changes to `data_in` have no effect on the frame in flight.
  - `valid_in` while `ready_out = 0` is ignored; no queueing, no error flag.
- States, with a bit counter (0..7) and a baud counter (0..`CLKS_PER_BIT`-1):
  - IDLE: `tx = 1`, `ready_out = 1`, `busy = 0`. Acceptance moves to START.
  - START: `tx = 0` for `CLKS_PER_BIT` cycles, then DATA.
  - DATA: `tx` = current shift-register LSB for `CLKS_PER_BIT` cycles per bit, shifting right after each bit. After bit 7 → PARITY if `PARITY != 0`, else STOP.
  - PARITY: `tx` = XOR of the 8 latched bits (even), or its inverse (odd), for `CLKS_PER_BIT` cycles, then STOP.
  - STOP: `tx = 1` for `STOP_BITS * CLKS_PER_BIT` cycles, then IDLE.
- The baud counter resets to 0 at every bit boundary and never wraps inside a bit.
- Reset (any state, including mid-frame) forces IDLE on the next edge: `tx = 1`, `ready_out = 1`, `busy = 0`, counters 0. The partial frame is abandoned with no completion.
- Reset values: `tx = 1`, `ready_out = 1`, `busy = 0`.

## Timing

- Acceptance at edge E0 gives, from E0 onward:
  - `tx = 0`, `ready_out = 0`, `busy = 1`.
  - Start-bit latency is 0 cycles after the accepting edge; `tx` is registered, so there is no combinational path from `valid_in` to `tx`.
- Bit k (k = 0 start, k = 1..8 data, then parity, then stop) occupies edges `E0 + k*CLKS_PER_BIT` up to `E0 + (k+1)*CLKS_PER_BIT`.
- At edge `E0 + N*CLKS_PER_BIT` the block returns to IDLE: `ready_out = 1`, `busy = 0`, `tx = 1`.
- Back-to-back frames: with `valid_in` held high, the next acceptance happens at `E0 + N*CLKS_PER_BIT + 1`.
  - Frame period is `N*CLKS_PER_BIT + 1` cycles.
  - There is exactly one extra idle-high cycle between frames.
- `ready_out` depends only on state and never on `valid_in` in the same cycle.

## Test plan

- **Reset and idle.** Assert `rst` for 3 cycles with `valid_in = 1`, then release with `valid_in = 0` → during reset, `tx = 1`, `ready_out = 1`, `busy = 0`, no acceptance; after release, `tx` stays 1 indefinitely.
- **Single 8N1 frame.** `CLKS_PER_BIT = 4`, send 0xA5 → `tx` sampled at mid-bit reads 0,1,0,1,0,0,1,0,1,1; `ready_out` returns high exactly 40 cycles after acceptance.
- **Parity.** `PARITY = 1`, send 0x07 → parity bit is 1. `PARITY = 2`, send 0x07 → parity bit is 0. `PARITY = 1`, send 0x00 → parity bit is 0. Each frame is 11 bits (44 cycles at `CLKS_PER_BIT = 4`).
- **Back-to-back and data stability.** Hold `valid_in = 1`; present 0x3C, then change `data_in` to 0xFF one cycle after acceptance → first frame carries 0x3C; second frame starts exactly 41 cycles after the first acceptance and carries 0xFF.
- **Ignore while busy.** Pulse `valid_in` with 0x55 in the middle of a frame → the pulse is not accepted and the in-flight frame is unchanged.
- **Reset mid-frame and 2 stop bits.** With `STOP_BITS = 2`, assert `rst` during data bit 3 → `tx = 1` on the next edge. Then send 0x81 → full frame of 11 bits, ending with 8 high cycles of stop (at `CLKS_PER_BIT = 4`).

Source files
------------

// File: rtl/heichips25_result_uart_tx.sv
// UART serializer for an 8-bit result bus: start, 8 data bits LSB first,
// optional parity, 1 or 2 stop bits, one byte per valid/ready handshake.
module heichips25_result_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       tx,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    // Wide enough for two stop bits at the largest legal CLKS_PER_BIT.
    localparam logic [16:0] BIT_LAST  = 17'(CLKS_PER_BIT - 1);
    localparam logic [16:0] STOP_LAST = 17'(STOP_BITS * CLKS_PER_BIT - 1);

    state_t      state_q, state_n;
    logic [16:0] baud_q, baud_n;
    logic [2:0]  bit_q, bit_n;
    logic [7:0]  shift_q, shift_n;
    logic        par_q, par_n;
    logic        tx_n, ready_n, busy_n;

    always_comb begin
        state_n = state_q;
        baud_n  = baud_q + 17'd1;
        bit_n   = bit_q;
        shift_n = shift_q;
        par_n   = par_q;
        case (state_q)
            S_IDLE: begin
                baud_n = '0;
                bit_n  = '0;
                if (valid_in && ready_out) begin
                    state_n = S_START;
                    shift_n = data_in;
                    // Parity is captured at acceptance since the shifter is consumed.
                    par_n   = (PARITY == 2) ? ~^data_in : ^data_in;
                end
            end
            S_START: begin
                if (baud_q == BIT_LAST) begin
                    baud_n  = '0;
                    state_n = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_q == BIT_LAST) begin
                    baud_n  = '0;
                    shift_n = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        bit_n   = '0;
                        state_n = (PARITY != 0) ? S_PAR : S_STOP;
                    end else begin
                        bit_n = bit_q + 3'd1;
                    end
                end
            end
            S_PAR: begin
                if (baud_q == BIT_LAST) begin
                    baud_n  = '0;
                    state_n = S_STOP;
                end
            end
            S_STOP: begin
                if (baud_q == STOP_LAST) begin
                    baud_n  = '0;
                    state_n = S_IDLE;
                end
            end
            default: begin
                baud_n  = '0;
                bit_n   = '0;
                state_n = S_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they change on the same edge.
        case (state_n)
            S_START: tx_n = 1'b0;
            S_DATA:  tx_n = shift_n[0];
            S_PAR:   tx_n = par_n;
            default: tx_n = 1'b1;
        endcase
        ready_n = (state_n == S_IDLE);
        busy_n  = (state_n != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            tx        <= 1'b1;
            ready_out <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_n;
            baud_q    <= baud_n;
            bit_q     <= bit_n;
            shift_q   <= shift_n;
            par_q     <= par_n;
            tx        <= tx_n;
            ready_out <= ready_n;
            busy      <= busy_n;
        end
    end

endmodule

// File: tb/tb_heichips25_result_uart_tx.sv
// Directed bench for the result UART: four instances covering 8N1, even and
// odd parity, and two stop bits, all at four clocks per bit.
module tb_heichips25_result_uart_tx;

    localparam int C = 4;

    logic       clk = 1'b0;
    logic [3:0] rst_v;
    logic [3:0] valid_v;
    logic [7:0] din [4];
    logic [3:0] tx_w, ready_w, busy_w;

    int checks = 0;
    int fails  = 0;
    bit exp_q[$];

    always #5 clk = ~clk;

    heichips25_result_uart_tx #(.CLKS_PER_BIT(C), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst(rst_v[0]), .data_in(din[0]), .valid_in(valid_v[0]),
        .ready_out(ready_w[0]), .tx(tx_w[0]), .busy(busy_w[0]));
    heichips25_result_uart_tx #(.CLKS_PER_BIT(C), .PARITY(1), .STOP_BITS(1)) u1 (
        .clk(clk), .rst(rst_v[1]), .data_in(din[1]), .valid_in(valid_v[1]),
        .ready_out(ready_w[1]), .tx(tx_w[1]), .busy(busy_w[1]));
    heichips25_result_uart_tx #(.CLKS_PER_BIT(C), .PARITY(2), .STOP_BITS(1)) u2 (
        .clk(clk), .rst(rst_v[2]), .data_in(din[2]), .valid_in(valid_v[2]),
        .ready_out(ready_w[2]), .tx(tx_w[2]), .busy(busy_w[2]));
    heichips25_result_uart_tx #(.CLKS_PER_BIT(C), .PARITY(0), .STOP_BITS(2)) u3 (
        .clk(clk), .rst(rst_v[3]), .data_in(din[3]), .valid_in(valid_v[3]),
        .ready_out(ready_w[3]), .tx(tx_w[3]), .busy(busy_w[3]));

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input int i, input string tag);
        check({tag, " tx"}, tx_w[i], 1'b1);
        check({tag, " ready"}, ready_w[i], 1'b1);
        check({tag, " busy"}, busy_w[i], 1'b0);
    endtask

    // mode 0: drop valid after acceptance; 1: hold valid and switch data to 0xFF;
    // 2: pulse valid with 0x55 in the middle of the frame.
    task automatic run_frame(input int i, input logic [7:0] b, input int pmode,
                             input int stops, input int mode);
        int n;
        bit e;
        n = 9 + ((pmode != 0) ? 1 : 0) + stops;
        exp_q.push_back(1'b0);
        for (int k = 0; k < 8; k++) exp_q.push_back(b[k]);
        if (pmode == 1) exp_q.push_back(^b);
        if (pmode == 2) exp_q.push_back(~^b);
        for (int k = 0; k < stops; k++) exp_q.push_back(1'b1);

        check("ready before accept", ready_w[i], 1'b1);
        @(posedge clk); #1;
        check("accept tx", tx_w[i], 1'b0);
        check("accept ready", ready_w[i], 1'b0);
        check("accept busy", busy_w[i], 1'b1);
        if (mode == 1) din[i] = 8'hFF;
        else valid_v[i] = 1'b0;

        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < ((k == 0) ? 2 : C); j++) begin
                @(posedge clk); #1;
                if (mode == 2) valid_v[i] = 1'b0;
            end
            e = exp_q.pop_front();
            check($sformatf("frame %02h bit %0d", b, k), tx_w[i], e);
            if (mode == 2 && k == 4) begin
                valid_v[i] = 1'b1;
                din[i]     = 8'h55;
            end
        end
        @(posedge clk); #1;
        check("last cycle ready", ready_w[i], 1'b0);
        check("last cycle busy", busy_w[i], 1'b1);
        @(posedge clk); #1;
        check_idle(i, "frame end");
    endtask

    initial begin
        rst_v   = 4'hF;
        valid_v = 4'hF;
        for (int i = 0; i < 4; i++) din[i] = 8'h5A;

        // Reset held with valid high: idle outputs, no acceptance.
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 4; i++) check_idle(i, "in reset");
        end
        rst_v   = 4'h0;
        valid_v = 4'h0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            check("idle tx", tx_w[0], 1'b1);
        end

        // 8N1 frame of 0xA5.
        din[0] = 8'hA5; valid_v[0] = 1'b1;
        run_frame(0, 8'hA5, 0, 1, 0);

        // Parity variants.
        din[1] = 8'h07; valid_v[1] = 1'b1;
        run_frame(1, 8'h07, 1, 1, 0);
        din[2] = 8'h07; valid_v[2] = 1'b1;
        run_frame(2, 8'h07, 2, 1, 0);
        din[1] = 8'h00; valid_v[1] = 1'b1;
        run_frame(1, 8'h00, 1, 1, 0);

        // Back-to-back with data changing after acceptance.
        din[0] = 8'h3C; valid_v[0] = 1'b1;
        run_frame(0, 8'h3C, 0, 1, 1);
        run_frame(0, 8'hFF, 0, 1, 0);

        // valid pulse during a frame is ignored.
        repeat (3) @(posedge clk); #1;
        din[0] = 8'hC3; valid_v[0] = 1'b1;
        run_frame(0, 8'hC3, 0, 1, 2);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check_idle(0, "after ignored pulse");
        end

        // Reset during data bit 3 on the two-stop-bit instance.
        din[3] = 8'h00; valid_v[3] = 1'b1;
        @(posedge clk); #1;
        check("mid accept busy", busy_w[3], 1'b1);
        valid_v[3] = 1'b0;
        repeat (4 * C + 1) @(posedge clk);
        #1;
        check("data bit 3 low", tx_w[3], 1'b0);
        rst_v[3] = 1'b1;
        @(posedge clk); #1;
        check_idle(3, "mid-frame reset");
        rst_v[3] = 1'b0;
        @(posedge clk); #1;
        check_idle(3, "after reset release");

        din[3] = 8'h81; valid_v[3] = 1'b1;
        run_frame(3, 8'h81, 0, 2, 0);

        check("scoreboard drained", exp_q.size() == 0, 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
